// File: rtl/cache_memory_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : cache_memory_arbiter_if
// Desc   : Cache-side request/response bundle for cache_memory_arbiter.
//          Optional ARB_STATS_EN adds the served/conflict counters.
// Rev    : 1.0
// ============================================================================
interface cache_memory_arbiter_if;
  logic         i_read;
  logic [5:0]   i_address;
  logic [127:0] i_readdata;
  logic         i_busywait;
  logic         d_read;
  logic         d_write;
  logic [5:0]   d_address;
  logic [31:0]  d_writedata;
  logic [31:0]  d_readdata;
  logic         d_busywait;
`ifdef ARB_STATS_EN
  logic [15:0]  i_count;
  logic [15:0]  d_count;
  logic [15:0]  conflict_count;

  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_writedata,
    input  i_readdata, i_busywait, d_readdata, d_busywait,
    input  i_count, d_count, conflict_count
  );
  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_writedata,
    output i_readdata, i_busywait, d_readdata, d_busywait,
    output i_count, d_count, conflict_count
  );
`else
  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_writedata,
    input  i_readdata, i_busywait, d_readdata, d_busywait
  );
  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_writedata,
    output i_readdata, i_busywait, d_readdata, d_busywait
  );
`endif
endinterface
`default_nettype wire

// File: rtl/cache_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module : cache_memory_arbiter
// Desc   : Single-ported backing store shared by I-cache refills and D-cache
//          reads/write-backs, fixed latency, round-robin on conflict.
//          Optional macro ARB_STATS_EN adds saturating usage counters.
// Rev    : 1.0
// ============================================================================
module cache_memory_arbiter #(
  parameter int unsigned LATENCY = 5,
  parameter int unsigned IBASE   = 0,
  parameter int unsigned DBASE   = 1024
) (
  input wire logic              clock,
  input wire logic              reset,
  cache_memory_arbiter_if.slave bus
);
  localparam int unsigned MEM_BYTES = 1280;
  localparam logic [10:0] IBASE_A   = 11'(IBASE);
  localparam logic [10:0] DBASE_A   = 11'(DBASE);
  localparam logic [7:0]  LAT_LOAD  = 8'(LATENCY - 1);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_DONE = 2'd2} state_t;
  typedef enum logic {PORT_I = 1'b0, PORT_D = 1'b1} port_t;

  state_t       state_q, state_d;
  logic [7:0]   counter_q, counter_d;
  port_t        served_q, served_d;
  port_t        last_q, last_d;
  logic [5:0]   addr_q, addr_d;
  logic         wr_q, wr_d;
  logic [31:0]  wdata_q, wdata_d;
  logic [127:0] i_rdata_q, i_rdata_d;
  logic [31:0]  d_rdata_q, d_rdata_d;
  logic [7:0]   mem_q [MEM_BYTES];

  logic  i_req;
  logic  d_req;
  logic  do_access;
  port_t pick;

  assign i_req     = bus.i_read;
  assign d_req     = bus.d_read | bus.d_write;
  assign do_access = (state_q == ST_BUSY) && (counter_q == 8'd0);

  assign bus.i_busywait = i_req & ~((state_q == ST_DONE) && (served_q == PORT_I));
  assign bus.d_busywait = d_req & ~((state_q == ST_DONE) && (served_q == PORT_D));
  assign bus.i_readdata = i_rdata_q;
  assign bus.d_readdata = d_rdata_q;

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    served_d  = served_q;
    last_d    = last_q;
    addr_d    = addr_q;
    wr_d      = wr_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    pick      = PORT_I;
    case (state_q)
      ST_IDLE: begin
        if (i_req || d_req) begin
          // On a conflict the port that was not served last wins
          if (i_req && d_req)
            pick = (last_q == PORT_I) ? PORT_D : PORT_I;
          else
            pick = d_req ? PORT_D : PORT_I;
          if (pick == PORT_D) begin
            addr_d  = bus.d_address;
            wr_d    = bus.d_write;
            wdata_d = bus.d_writedata;
          end else begin
            addr_d  = bus.i_address;
            wr_d    = 1'b0;
          end
          served_d  = pick;
          last_d    = pick;
          counter_d = LAT_LOAD;
          state_d   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (counter_q == 8'd0) begin
          state_d = ST_DONE;
          if (served_q == PORT_I) begin
            for (int k = 0; k < 16; k++)
              i_rdata_d[8*k +: 8] = mem_q[IBASE_A + {1'b0, addr_q, 4'b0000} + 11'(k)];
          end else if (!wr_q) begin
            for (int k = 0; k < 4; k++)
              d_rdata_d[8*k +: 8] = mem_q[DBASE_A + {3'b000, addr_q, 2'b00} + 11'(k)];
          end
        end else begin
          counter_d = counter_q - 8'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      counter_q <= '0;
      served_q  <= PORT_I;
      last_q    <= PORT_I;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      served_q  <= served_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Reset forces state to IDLE asynchronously, so an aborted write never commits
  always_ff @(posedge clock) begin
    if (do_access && (served_q == PORT_D) && wr_q) begin
      for (int k = 0; k < 4; k++)
        mem_q[DBASE_A + {3'b000, addr_q, 2'b00} + 11'(k)] <= wdata_q[8*k +: 8];
    end
  end

`ifdef ARB_STATS_EN
  logic [15:0] i_count_q, d_count_q, conflict_count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      i_count_q        <= '0;
      d_count_q        <= '0;
      conflict_count_q <= '0;
    end else begin
      if ((state_q == ST_DONE) && (served_q == PORT_I) && (i_count_q != 16'hFFFF))
        i_count_q <= i_count_q + 16'd1;
      if ((state_q == ST_DONE) && (served_q == PORT_D) && (d_count_q != 16'hFFFF))
        d_count_q <= d_count_q + 16'd1;
      if ((state_q == ST_IDLE) && i_req && d_req && (conflict_count_q != 16'hFFFF))
        conflict_count_q <= conflict_count_q + 16'd1;
    end
  end

  assign bus.i_count        = i_count_q;
  assign bus.d_count        = d_count_q;
  assign bus.conflict_count = conflict_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_cache_memory_arbiter
// Desc   : Directed bench with a transaction-timeline model of the arbiter.
// Rev    : 1.0
// ============================================================================
module tb_cache_memory_arbiter;
  localparam int LAT = 5;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  cache_memory_arbiter_if bus ();
  cache_memory_arbiter_if bus1 ();

  cache_memory_arbiter #(.LATENCY(LAT), .IBASE(0), .DBASE(1024)) dut (
    .clock(clock), .reset(reset), .bus(bus));
  cache_memory_arbiter #(.LATENCY(1), .IBASE(0), .DBASE(1024)) dut1 (
    .clock(clock), .reset(reset), .bus(bus1));

  int n_checks = 0;
  int n_fail   = 0;
  int tb_edges = 0;
  bit checking_on = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int k);
    return (k < 1024) ? 8'(k) : 8'(k * 7 + 3);
  endfunction

  // Timeline model: edges are counted from reset release
  logic [7:0]   m_mem [1280];
  int           edge_n = 0, m_done_edge = 0, m_next_ok = 0;
  bit           m_active = 0, m_done = 0, m_port_d = 0, m_last_d = 0, m_wr = 0;
  logic [5:0]   m_addr = '0;
  logic [31:0]  m_wdata = '0;
  logic [127:0] m_irdata = '0;
  logic [31:0]  m_drdata = '0;
  int           m_icnt = 0, m_dcnt = 0, m_conf = 0;

  task automatic model_step();
    bit ir, dr;
    edge_n++;
    if (m_done) begin
      if (m_port_d) m_dcnt++; else m_icnt++;
    end
    m_done = 0;
    ir = bus.i_read;
    dr = bus.d_read | bus.d_write;
    if (m_active && edge_n == m_done_edge) begin
      if (!m_port_d) begin
        for (int k = 0; k < 16; k++) m_irdata[8*k +: 8] = m_mem[16*int'(m_addr) + k];
      end else if (m_wr) begin
        for (int k = 0; k < 4; k++) m_mem[1024 + 4*int'(m_addr) + k] = m_wdata[8*k +: 8];
      end else begin
        for (int k = 0; k < 4; k++) m_drdata[8*k +: 8] = m_mem[1024 + 4*int'(m_addr) + k];
      end
      m_done    = 1;
      m_active  = 0;
      m_next_ok = edge_n + 2;
    end else if (!m_active && edge_n >= m_next_ok) begin
      if (ir && dr) m_conf++;
      if (ir || dr) begin
        m_port_d    = dr && (!ir || !m_last_d);
        m_last_d    = m_port_d;
        m_addr      = m_port_d ? bus.d_address : bus.i_address;
        m_wr        = m_port_d && bus.d_write;
        m_wdata     = bus.d_writedata;
        m_active    = 1;
        m_done_edge = edge_n + LAT;
      end
    end
  endtask

  initial forever begin
    @(posedge clock or posedge reset);
    if (reset) begin
      edge_n = 0; m_active = 0; m_done = 0; m_last_d = 0; m_next_ok = 0;
      m_irdata = '0; m_drdata = '0; m_icnt = 0; m_dcnt = 0; m_conf = 0;
    end else begin
      model_step();
    end
  end

  initial forever begin
    @(posedge clock);
    tb_edges++;
  end

  initial forever begin
    @(negedge clock);
    if (checking_on) begin
      check("i_busywait", 128'(bus.i_busywait), 128'(bus.i_read & !(m_done && !m_port_d)));
      check("d_busywait", 128'(bus.d_busywait),
            128'((bus.d_read | bus.d_write) & !(m_done && m_port_d)));
      check("i_readdata", bus.i_readdata, m_irdata);
      check("d_readdata", 128'(bus.d_readdata), 128'(m_drdata));
`ifdef ARB_STATS_EN
      check("i_count", 128'(bus.i_count), 128'(m_icnt));
      check("d_count", 128'(bus.d_count), 128'(m_dcnt));
      check("conflict_count", 128'(bus.conflict_count), 128'(m_conf));
`endif
    end
  end

  task automatic access_d(input bit wr, input logic [5:0] a, input logic [31:0] wd,
                          output int stall, output logic [31:0] got);
    @(posedge clock); #1;
    bus.d_read = !wr; bus.d_write = wr; bus.d_address = a; bus.d_writedata = wd;
    stall = 0;
    got = '0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clock);
      if (!bus.d_busywait) begin
        got = bus.d_readdata;
        break;
      end
      stall++;
    end
    @(posedge clock); #1;
    bus.d_read = 0; bus.d_write = 0;
  endtask

  task automatic access_i(input logic [5:0] a, output int stall, output logic [127:0] got);
    @(posedge clock); #1;
    bus.i_read = 1; bus.i_address = a;
    stall = 0;
    got = '0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clock);
      if (!bus.i_busywait) begin
        got = bus.i_readdata;
        break;
      end
      stall++;
    end
    @(posedge clock); #1;
    bus.i_read = 0;
  endtask

  // Both ports raise a read in the same cycle; returns completion edges relative to the raise
  task automatic conflict(input logic [5:0] ia, input logic [5:0] da,
                          output int i_edge, output int d_edge);
    int c0;
    @(posedge clock); #1;
    c0 = tb_edges;
    bus.i_read = 1; bus.i_address = ia;
    bus.d_read = 1; bus.d_address = da;
    i_edge = -1;
    d_edge = -1;
    for (int n = 0; n < 60 && (i_edge < 0 || d_edge < 0); n++) begin
      @(negedge clock);
      if (bus.d_read && !bus.d_busywait && d_edge < 0) d_edge = tb_edges - c0;
      if (bus.i_read && !bus.i_busywait && i_edge < 0) i_edge = tb_edges - c0;
      @(posedge clock); #1;
      if (d_edge >= 0) bus.d_read = 0;
      if (i_edge >= 0) bus.i_read = 0;
    end
    bus.i_read = 0;
    bus.d_read = 0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int           stall, ie, de;
    logic [31:0]  dgot;
    logic [127:0] igot;
    logic [5:0]   exp_bw;

    bus.i_read = 0; bus.i_address = '0; bus.d_read = 0; bus.d_write = 0;
    bus.d_address = '0; bus.d_writedata = '0;
    bus1.i_read = 0; bus1.i_address = '0; bus1.d_read = 0; bus1.d_write = 0;
    bus1.d_address = '0; bus1.d_writedata = '0;
    for (int k = 0; k < 1280; k++) begin
      dut.mem_q[k]  = pat(k);
      dut1.mem_q[k] = pat(k);
      m_mem[k]      = pat(k);
    end

    @(negedge clock);
    checking_on = 1;
    check("reset i_readdata", bus.i_readdata, 128'h0);
    check("reset d_readdata", 128'(bus.d_readdata), 128'h0);
    @(posedge clock); #1;
    reset = 0;

    // Instruction block refill of block 0
    access_i(6'd0, stall, igot);
    check("i stall cycles", 128'(stall), 128'd6);
    check("i block 0", igot, 128'h0F0E0D0C0B0A09080706050403020100);

    // First conflict after reset: D wins
    conflict(6'd1, 6'd2, ie, de);
    check("conflict1 d edge", 128'(de), 128'd6);
    check("conflict1 i edge", 128'(ie), 128'd13);

    // Write-back then read-back of block 3
    access_d(1'b1, 6'h03, 32'hDEADBEEF, stall, dgot);
    check("d write stall", 128'(stall), 128'd6);
    access_d(1'b0, 6'h03, 32'h0, stall, dgot);
    check("d readback", 128'(dgot), 128'hDEADBEEF);
    check("mem[1036]", 128'(dut.mem_q[1036]), 128'hEF);

    // Last served was D, so I wins this conflict
    conflict(6'd2, 6'd3, ie, de);
    check("conflict2 i edge", 128'(ie), 128'd6);
    check("conflict2 d edge", 128'(de), 128'd13);

    // Reset during the third BUSY cycle of a write
    @(posedge clock); #1;
    bus.d_write = 1; bus.d_address = 6'h05; bus.d_writedata = 32'h12345678;
    repeat (3) @(posedge clock);
    #1;
    reset = 1;
    @(negedge clock);
    check("abort d_readdata", 128'(bus.d_readdata), 128'h0);
    check("abort i_readdata", bus.i_readdata, 128'h0);
    bus.d_write = 0;
    @(posedge clock); #1;
    reset = 0;
    check("abort mem", 128'({dut.mem_q[1047], dut.mem_q[1046], dut.mem_q[1045], dut.mem_q[1044]}),
          128'hA49D968F);
    access_d(1'b0, 6'h05, 32'h0, stall, dgot);
    check("post-abort stall", 128'(stall), 128'd6);
    check("post-abort read", 128'(dgot), 128'hA49D968F);
`ifdef ARB_STATS_EN
    check("stats i_count", 128'(bus.i_count), 128'd0);
    check("stats d_count", 128'(bus.d_count), 128'd1);
    check("stats conflict", 128'(bus.conflict_count), 128'd0);
`endif

    // LATENCY=1 instance: back-to-back reads of blocks 0 and 1
    exp_bw = 6'b011011;
    @(posedge clock); #1;
    bus1.d_read = 1; bus1.d_address = 6'h00;
    for (int n = 0; n < 6; n++) begin
      @(negedge clock);
      check("lat1 d_busywait", 128'(bus1.d_busywait), 128'(exp_bw[n]));
      if (n == 2) begin
        check("lat1 block 0", 128'(bus1.d_readdata), 128'h18110A03);
        @(posedge clock); #1;
        bus1.d_address = 6'h01;
      end
      if (n == 5) check("lat1 block 1", 128'(bus1.d_readdata), 128'h342D261F);
    end
    @(posedge clock); #1;
    bus1.d_read = 0;

    repeat (2) @(posedge clock);
    checking_on = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
